multicycle_maindec: RTL and testbench

//  Main control FSM for the multicycle MIPS datapath; sits directly upstream of aludec.

---
 rtl/mips_ctrl_pkg.sv | 70 +++++++
 rtl/maindec_outdec.sv | 67 ++++++
 rtl/multicycle_maindec.sv | 103 ++++++++++
 tb/tb_multicycle_maindec.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/mips_ctrl_pkg.sv
// Shared control definitions for the multicycle MIPS controller.
// Holds the opcode constants, the FSM state encodings, the aluop codes that
// aludec also imports, the datapath mux-select codes, and the packed control
// word that maindec_outdec produces.
package mips_ctrl_pkg;

  localparam int STATE_W = 4;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  localparam logic [1:0] SRCB_B     = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_IMMSH = 2'b11;

  // 12 used encodings; 12..15 are unused and recover to FETCH.
  typedef enum logic [STATE_W-1:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMRD    = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWR    = 4'd5,
    S_EXECUTE  = 4'd6,
    S_ALUWB    = 4'd7,
    S_BRANCH   = 4'd8,
    S_ADDIEXEC = 4'd9,
    S_ADDIWB   = 4'd10,
    S_JUMP     = 4'd11
  } state_t;

  // 16-bit control word. memwait marks states that touch memory and may
  // have to stall on mem_ready; it is internal and never leaves the block.
  typedef struct packed {
    logic       memwait;
    logic       memwrite;
    logic       lord;
    logic       irwrite;
    logic       pcwrite;
    logic       branch;
    logic [1:0] pcsrc;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] aluop;
    logic       regdst;
    logic       memtoreg;
    logic       regwrite;
  } ctrl_t;

  function automatic logic op_supported(input logic [5:0] op);
    case (op)
      OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J: op_supported = 1'b1;
      default:                                       op_supported = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/maindec_outdec.sv
// Combinational state -> control word decoder (Moore output table).
// Ports:
//   state_i  in   registered FSM state
//   cw_o     out  16-bit control word; all fields 0 unless set for the state
module maindec_outdec
  import mips_ctrl_pkg::*;
(
  input  state_t state_i,
  output ctrl_t  cw_o
);

  always_comb begin
    cw_o = '0;
    case (state_i)
      S_FETCH: begin
        cw_o.memwait = 1'b1;
        cw_o.irwrite = 1'b1;
        cw_o.pcwrite = 1'b1;
        cw_o.alusrcb = SRCB_FOUR;
      end
      // Branch target is precomputed here while the opcode is decoded.
      S_DECODE:   cw_o.alusrcb = SRCB_IMMSH;
      S_MEMADR: begin
        cw_o.alusrca = 1'b1;
        cw_o.alusrcb = SRCB_IMM;
      end
      S_MEMRD: begin
        cw_o.memwait = 1'b1;
        cw_o.lord    = 1'b1;
      end
      S_MEMWB: begin
        cw_o.memtoreg = 1'b1;
        cw_o.regwrite = 1'b1;
      end
      S_MEMWR: begin
        cw_o.memwait  = 1'b1;
        cw_o.lord     = 1'b1;
        cw_o.memwrite = 1'b1;
      end
      S_EXECUTE: begin
        cw_o.alusrca = 1'b1;
        cw_o.aluop   = ALUOP_FUNCT;
      end
      S_ALUWB: begin
        cw_o.regdst   = 1'b1;
        cw_o.regwrite = 1'b1;
      end
      S_BRANCH: begin
        cw_o.alusrca = 1'b1;
        cw_o.aluop   = ALUOP_SUB;
        cw_o.pcsrc   = PCSRC_ALUOUT;
        cw_o.branch  = 1'b1;
      end
      S_ADDIEXEC: begin
        cw_o.alusrca = 1'b1;
        cw_o.alusrcb = SRCB_IMM;
      end
      S_ADDIWB:   cw_o.regwrite = 1'b1;
      S_JUMP: begin
        cw_o.pcsrc   = PCSRC_JUMP;
        cw_o.pcwrite = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/multicycle_maindec.sv
// Main control FSM for the multicycle MIPS datapath (feeds aludec).
// Sequences FETCH/DECODE/execute/writeback and drives all datapath enables
// and mux selects. Optional macro MAINDEC_MEMWAIT_EN adds mem_ready, which
// stalls FETCH, MEMRD and MEMWR; without it memory is treated as always ready.
// Ports:
//   clk, reset (async, active-high), mem_ready (MAINDEC_MEMWAIT_EN only),
//   op[5:0] in; memwrite, lord, irwrite, pcwrite, branch, pcsrc[1:0],
//   alusrca, alusrcb[1:0], aluop[1:0], regdst, memtoreg, regwrite,
//   illegal_op out.
module multicycle_maindec
  import mips_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
`ifdef MAINDEC_MEMWAIT_EN
  input  logic       mem_ready,
`endif
  input  logic [5:0] op,
  output logic       memwrite,
  output logic       lord,
  output logic       irwrite,
  output logic       pcwrite,
  output logic       branch,
  output logic [1:0] pcsrc,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] aluop,
  output logic       regdst,
  output logic       memtoreg,
  output logic       regwrite,
  output logic       illegal_op
);

  state_t state_q, state_d;
  ctrl_t  cw;
  logic   mem_rdy;
  logic   go;

`ifdef MAINDEC_MEMWAIT_EN
  assign mem_rdy = mem_ready;
`else
  assign mem_rdy = 1'b1;
`endif

  maindec_outdec u_outdec (
    .state_i (state_q),
    .cw_o    (cw)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    illegal_op = 1'b0;
    go         = ~reset;

    case (state_q)
      S_FETCH:  if (mem_rdy) state_d = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_EXECUTE;
          OP_BEQ:       state_d = S_BRANCH;
          OP_ADDI:      state_d = S_ADDIEXEC;
          OP_J:         state_d = S_JUMP;
          default:      state_d = S_FETCH;
        endcase
        illegal_op = go & ~op_supported(op);
      end
      // Anything other than sw takes the load path.
      S_MEMADR:   state_d = (op == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:    if (mem_rdy) state_d = S_MEMWB;
      S_MEMWB:    state_d = S_FETCH;
      S_MEMWR:    if (mem_rdy) state_d = S_FETCH;
      S_EXECUTE:  state_d = S_ALUWB;
      S_ALUWB:    state_d = S_FETCH;
      S_BRANCH:   state_d = S_FETCH;
      S_ADDIEXEC: state_d = S_ADDIWB;
      S_ADDIWB:   state_d = S_FETCH;
      S_JUMP:     state_d = S_FETCH;
      default:    state_d = S_FETCH;
    endcase

    // While stalled in FETCH the IR/PC loads must not fire; JUMP's pcwrite
    // has memwait clear and is never gated.
    memwrite = go & cw.memwrite;
    lord     = go & cw.lord;
    irwrite  = go & cw.irwrite & (~cw.memwait | mem_rdy);
    pcwrite  = go & cw.pcwrite & (~cw.memwait | mem_rdy);
    branch   = go & cw.branch;
    pcsrc    = cw.pcsrc & {2{go}};
    alusrca  = go & cw.alusrca;
    alusrcb  = cw.alusrcb & {2{go}};
    aluop    = cw.aluop & {2{go}};
    regdst   = go & cw.regdst;
    memtoreg = go & cw.memtoreg;
    regwrite = go & cw.regwrite;
  end

endmodule

// File: tb/tb_multicycle_maindec.sv
// Self-checking bench for multicycle_maindec: directed table, reset and
// memory-wait sequences, and random instruction streams against a
// per-instruction output-sequence model.
module tb_multicycle_maindec;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] op;
`ifdef MAINDEC_MEMWAIT_EN
  logic       mem_ready = 1'b1;
`endif
  logic       memwrite, lord, irwrite, pcwrite, branch, alusrca;
  logic       regdst, memtoreg, regwrite, illegal_op;
  logic [1:0] pcsrc, alusrcb, aluop;

  multicycle_maindec dut (
    .clk        (clk),
    .reset      (reset),
`ifdef MAINDEC_MEMWAIT_EN
    .mem_ready  (mem_ready),
`endif
    .op         (op),
    .memwrite   (memwrite),
    .lord       (lord),
    .irwrite    (irwrite),
    .pcwrite    (pcwrite),
    .branch     (branch),
    .pcsrc      (pcsrc),
    .alusrca    (alusrca),
    .alusrcb    (alusrcb),
    .aluop      (aluop),
    .regdst     (regdst),
    .memtoreg   (memtoreg),
    .regwrite   (regwrite),
    .illegal_op (illegal_op)
  );

  always #5 clk = ~clk;

  // {memwrite,lord,irwrite,pcwrite,branch,pcsrc,alusrca,alusrcb,aluop,
  //  regdst,memtoreg,regwrite,illegal_op}
  logic [15:0] act;
  assign act = {memwrite, lord, irwrite, pcwrite, branch, pcsrc, alusrca,
                alusrcb, aluop, regdst, memtoreg, regwrite, illegal_op};

  int pass_cnt = 0;
  int total    = 0;

  typedef logic [15:0] seq_t [6];

  typedef struct {
    logic [5:0]  op;
    int          n;
    logic [15:0] e [5];
  } vec_t;

  function automatic logic [15:0] cw(input logic mw, lo, ir, pw, br,
                                     input logic [1:0] ps, input logic sa,
                                     input logic [1:0] sb, ao,
                                     input logic rd, mr, rw, il);
    return {mw, lo, ir, pw, br, ps, sa, sb, ao, rd, mr, rw, il};
  endfunction

  // Expected output per cycle for one instruction, from the per-instruction
  // step list: fetch, decode, then the op-specific steps.
  function automatic void model(input logic [5:0] o, output int n, output seq_t s);
    for (int i = 0; i < 6; i++) s[i] = '0;
    s[0] = cw(0,0,1,1,0,2'b00,0,2'b01,2'b00,0,0,0,0);
    s[1] = cw(0,0,0,0,0,2'b00,0,2'b11,2'b00,0,0,0,0);
    case (o)
      6'b100011: begin n = 5;
        s[2] = cw(0,0,0,0,0,2'b00,1,2'b10,2'b00,0,0,0,0);
        s[3] = cw(0,1,0,0,0,2'b00,0,2'b00,2'b00,0,0,0,0);
        s[4] = cw(0,0,0,0,0,2'b00,0,2'b00,2'b00,0,1,1,0);
      end
      6'b101011: begin n = 4;
        s[2] = cw(0,0,0,0,0,2'b00,1,2'b10,2'b00,0,0,0,0);
        s[3] = cw(1,1,0,0,0,2'b00,0,2'b00,2'b00,0,0,0,0);
      end
      6'b000000: begin n = 4;
        s[2] = cw(0,0,0,0,0,2'b00,1,2'b00,2'b10,0,0,0,0);
        s[3] = cw(0,0,0,0,0,2'b00,0,2'b00,2'b00,1,0,1,0);
      end
      6'b000100: begin n = 3;
        s[2] = cw(0,0,0,0,1,2'b01,1,2'b00,2'b01,0,0,0,0);
      end
      6'b001000: begin n = 4;
        s[2] = cw(0,0,0,0,0,2'b00,1,2'b10,2'b00,0,0,0,0);
        s[3] = cw(0,0,0,0,0,2'b00,0,2'b00,2'b00,0,0,1,0);
      end
      6'b000010: begin n = 3;
        s[2] = cw(0,0,0,1,0,2'b10,0,2'b00,2'b00,0,0,0,0);
      end
      default: begin n = 2;
        s[1][0] = 1'b1;
      end
    endcase
  endfunction

  task automatic check(input string nm, input logic [15:0] exp);
    total++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %04h expected %04h", nm, act, exp);
  endtask

  // One clock cycle: inputs already driven at posedge+1, compare at negedge,
  // advance to the next posedge+1.
  task automatic cyc(input string nm, input logic [15:0] exp);
    @(negedge clk);
    check(nm, exp);
    @(posedge clk);
    #1;
  endtask

  // op is only meaningful in DECODE/MEMADR; scramble it elsewhere.
  task automatic run_instr(input string nm, input logic [5:0] o);
    int   n;
    seq_t s;
    model(o, n, s);
    for (int i = 0; i < n; i++) begin
      op = (i == 1 || i == 2) ? o : 6'($urandom);
      cyc($sformatf("%s_c%0d", nm, i), s[i]);
    end
  endtask

  vec_t tab [7];
  logic [5:0] ops [6];

  initial begin
    tab[0] = '{6'b100011, 5, '{16'h3040, 16'h00C0, 16'h0180, 16'h4000, 16'h0006}};
    tab[1] = '{6'b101011, 4, '{16'h3040, 16'h00C0, 16'h0180, 16'hC000, 16'h0000}};
    tab[2] = '{6'b000000, 4, '{16'h3040, 16'h00C0, 16'h0120, 16'h000A, 16'h0000}};
    tab[3] = '{6'b000100, 3, '{16'h3040, 16'h00C0, 16'h0B10, 16'h0000, 16'h0000}};
    tab[4] = '{6'b000010, 3, '{16'h3040, 16'h00C0, 16'h1400, 16'h0000, 16'h0000}};
    tab[5] = '{6'b001000, 4, '{16'h3040, 16'h00C0, 16'h0180, 16'h0002, 16'h0000}};
    tab[6] = '{6'b111111, 2, '{16'h3040, 16'h00C1, 16'h0000, 16'h0000, 16'h0000}};
    ops = '{6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b001000, 6'b000010};

    reset = 1'b1;
    op    = 6'b0;
    @(negedge clk);
    check("reset_hold", 16'h0000);
    @(posedge clk);
    #1 reset = 1'b0;

    // directed table
    for (int k = 0; k < 7; k++)
      for (int i = 0; i < tab[k].n; i++) begin
        op = (i == 1 || i == 2) ? tab[k].op : 6'($urandom);
        cyc($sformatf("tab%0d_c%0d", k, i), tab[k].e[i]);
      end

    // reset pulse in MEMWB: lw reaches cycle 5, then reset aborts it
    op = 6'b100011;
    for (int i = 0; i < 4; i++) cyc("rst_lw_pre", tab[0].e[i]);
    check("rst_in_memwb", 16'h0006);
    #2 reset = 1'b1;
    #1 check("rst_async_zero", 16'h0000);
    @(negedge clk);
    check("rst_mid_zero", 16'h0000);
    @(posedge clk);
    #1 reset = 1'b0;
    run_instr("post_rst_r", 6'b000000);

`ifdef MAINDEC_MEMWAIT_EN
    // FETCH stall, then sw with mem_ready low 3 cycles in MEMWR
    mem_ready = 1'b0;
    op = 6'b101011;
    cyc("mw_fetch_hold", 16'h0040);
    mem_ready = 1'b1;
    cyc("mw_fetch_go", 16'h3040);
    cyc("mw_decode", 16'h00C0);
    cyc("mw_memadr", 16'h0180);
    mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) cyc("mw_memwr_hold", 16'hC000);
    mem_ready = 1'b1;
    cyc("mw_memwr_done", 16'hC000);
    cyc("mw_back_fetch", 16'h3040);
    cyc("mw_decode2", 16'h00C0);
    cyc("mw_memadr2", 16'h0180);
    cyc("mw_memwr2", 16'hC000);
`endif

    // random instruction stream
    for (int k = 0; k < 60; k++) begin
      logic [5:0] o;
      if ($urandom_range(0, 7) < 6) o = ops[$urandom_range(0, 5)];
      else                          o = 6'($urandom);
      run_instr($sformatf("rnd%0d_op%02h", k, o), o);
    end

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
